// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
// Holds the default widths, the skid-buffer depth and the occupancy type.
package fifo_rd_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  // Skid-buffer occupancy: 0, 1 or 2 entries.
  typedef logic [1:0] occ_t;

  localparam occ_t SKID_DEPTH = 2'd2;

endpackage : fifo_rd_pkg

// File: rtl/fifo_rd_stream_skid.sv
// Two-entry valid/ready skid buffer.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   flush      : synchronous clear of the occupancy (overrides push and accept)
//   push       : write wdata into the buffer this cycle
//   wdata      : word to store
//   ready      : downstream accept
//   acc        : valid && ready (a word leaves the head this cycle)
//   valid      : buffer holds at least one word
//   data       : head entry (buf0), registered
//   level      : occupancy, 0..2
module skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ready,
  output logic                  acc,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output occ_t                  level
);

  logic [DATA_WIDTH-1:0] buf0_r, buf1_r;
  logic [DATA_WIDTH-1:0] buf0_s, buf1_s;
  occ_t                  cnt_r, cnt_s;

  assign valid = (cnt_r != 2'd0);
  assign acc   = valid && ready;
  assign data  = buf0_r;
  assign level = cnt_r;

  // Next-state for the two entries and the occupancy.
  always_comb begin
    buf0_s = buf0_r;
    buf1_s = buf1_r;
    cnt_s  = cnt_r;
    if (flush) begin
      cnt_s = 2'd0;
    end else begin
      case ({push, acc})
        2'b10: begin
          // Fill the head first; the second slot only when the head is taken.
          if (cnt_r == 2'd0) begin
            buf0_s = wdata;
          end else begin
            buf1_s = wdata;
          end
          cnt_s = cnt_r + 2'd1;
        end
        2'b01: begin
          buf0_s = buf1_r;
          cnt_s  = cnt_r - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry: replace the head, level unchanged.
          buf0_s = wdata;
        end
        default: begin
          cnt_s = cnt_r;
        end
      endcase
    end
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_r <= {DATA_WIDTH{1'b0}};
      buf1_r <= {DATA_WIDTH{1'b0}};
      cnt_r  <= 2'd0;
    end else begin
      buf0_r <= buf0_s;
      buf1_r <= buf1_s;
      cnt_r  <= cnt_s;
    end
  end

endmodule : skid_buf

// File: rtl/fifo_rd_stream.sv
// Read-side consumer adapter for the asynchronous FIFO (read clock domain).
// Pops first-word-fall-through words into a 2-entry skid buffer and presents
// them on a valid/ready stream, counting delivered words.
// Ports:
//   rclk, rrst_n     : read clock, asynchronous active-low reset
//   rempty, rdata    : FIFO empty flag (synchronized) and head word
//   rinc             : FIFO pop strobe (only combinational output)
//   flush            : synchronous clear of the skid buffer
//   m_valid, m_ready : stream handshake
//   m_data           : stream data (skid-buffer head)
//   level            : skid-buffer occupancy
//   rd_cnt           : words accepted downstream, wrapping
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            level,
  output logic [CNT_WIDTH-1:0]  rd_cnt
);

  logic                 acc_s;
  occ_t                 cnt_s;
  logic                 rinc_s;
  logic [CNT_WIDTH-1:0] rd_cnt_r;

  // Pop decision ignores m_ready so no combinational path reaches the FIFO
  // from downstream; held low during reset.
  assign rinc_s = rrst_n && !rempty && !flush && (cnt_s < SKID_DEPTH);
  assign rinc   = rinc_s;
  assign level  = cnt_s;
  assign rd_cnt = rd_cnt_r;

  skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk   (rclk),
    .rst_n (rrst_n),
    .flush (flush),
    .push  (rinc_s),
    .wdata (rdata),
    .ready (m_ready),
    .acc   (acc_s),
    .valid (m_valid),
    .data  (m_data),
    .level (cnt_s)
  );

  // Delivered-word counter; a flush cycle never counts.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (acc_s && !flush) begin
      rd_cnt_r <= rd_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rd_cnt_r <= rd_cnt_r;
    end
  end

endmodule : fifo_rd_stream

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream with a queue-based FIFO model.
module tb_fifo_rd_stream;

  logic        rclk;
  logic        rrst_n;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [1:0]  level;
  logic [15:0] rd_cnt;

  // Second instance with a 4-bit counter for the wrap check.
  logic        rempty_w;
  logic [7:0]  rdata_w;
  logic        rinc_w;
  logic        flush_w;
  logic        m_valid_w;
  logic        m_ready_w;
  logic [7:0]  m_data_w;
  logic [1:0]  level_w;
  logic [3:0]  rd_cnt_w;

  int pass_cnt;
  int total_cnt;
  int pops;
  logic bubble;
  logic [7:0] q[$];

  fifo_rd_stream dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level), .rd_cnt(rd_cnt)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty_w), .rdata(rdata_w), .rinc(rinc_w),
    .flush(flush_w), .m_valid(m_valid_w), .m_ready(m_ready_w), .m_data(m_data_w),
    .level(level_w), .rd_cnt(rd_cnt_w)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic update_fifo();
    rempty = (q.size() == 0) || bubble;
    rdata  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: pop the model FIFO if rinc was high, then settle.
  task automatic tick();
    logic pop;
    pop = rinc;
    @(posedge rclk);
    #1;
    if (pop) begin
      void'(q.pop_front());
      pops++;
    end
    update_fifo();
    #1;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; pops = 0; bubble = 1'b0;
    rrst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
    rempty_w = 1'b1; rdata_w = 8'h5A; flush_w = 1'b0; m_ready_w = 1'b0;
    update_fifo();

    // Reset state
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_data", m_data, 0);
    chk("rst_cnt", rd_cnt, 0);
    chk("rst_rinc", rinc, 0);
    #9 rrst_n = 1'b1;
    tick(); tick();
    chk("idle_valid", m_valid, 0);
    chk("idle_rinc", rinc, 0);

    // Streaming 0x01..0x08 with m_ready=1
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) q.push_back(8'(i));
    update_fifo(); #1;
    chk("stream_rinc0", rinc, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("stream_data%0d", i), m_data, i);
      chk($sformatf("stream_valid%0d", i), m_valid, 1);
    end
    tick();
    chk("stream_cnt", rd_cnt, 8);
    chk("stream_level", level, 0);
    chk("stream_valid_end", m_valid, 0);

    // Backpressure: exactly two pops then stall
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back(8'hA0 + 8'(i));
    update_fifo(); #1;
    tick(); tick();
    chk("bp_level", level, 2);
    chk("bp_rinc", rinc, 0);
    chk("bp_data", m_data, 8'hA0);
    tick();
    chk("bp_hold_data", m_data, 8'hA0);
    chk("bp_hold_level", level, 2);
    chk("bp_fifo_left", q.size(), 2);
    m_ready = 1'b1; #1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("bp_data_a%0d", i), m_data, 8'hA0 + i);
      chk($sformatf("bp_valid_a%0d", i), m_valid, 1);
    end
    tick();
    chk("bp_cnt", rd_cnt, 12);
    chk("bp_valid_end", m_valid, 0);

    // Bubbles: rempty alternates, one word every other cycle
    pops = 0;
    for (int i = 0; i < 4; i++) q.push_back(8'hB0 + 8'(i));
    update_fifo(); #1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      bubble = ~bubble;
      update_fifo(); #1;
      if (i % 2 == 1) begin
        chk($sformatf("bub_data%0d", i), m_data, 8'hB0 + (i - 1) / 2);
        chk($sformatf("bub_valid%0d", i), m_valid, 1);
      end else begin
        chk($sformatf("bub_gap%0d", i), m_valid, 0);
      end
    end
    chk("bub_pops", pops, 4);
    chk("bub_cnt", rd_cnt, 12 + pops);

    // Flush with two entries held and FIFO non-empty
    m_ready = 1'b0;
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    update_fifo(); #1;
    tick(); tick();
    chk("fl_level_pre", level, 2);
    chk("fl_data_pre", m_data, 8'h11);
    flush = 1'b1; m_ready = 1'b1; #1;
    chk("fl_rinc", rinc, 0);
    tick();
    flush = 1'b0; #1;
    chk("fl_level", level, 0);
    chk("fl_valid", m_valid, 0);
    chk("fl_cnt", rd_cnt, 16);
    chk("fl_head_kept", q.size(), 1);
    chk("fl_rinc_after", rinc, 1);
    tick();
    chk("fl_data_post", m_data, 8'h33);
    tick();
    chk("fl_cnt_post", rd_cnt, 17);

    // Reset mid-transfer with two entries held
    m_ready = 1'b0;
    q.push_back(8'h44); q.push_back(8'h55); q.push_back(8'h66);
    update_fifo(); #1;
    tick(); tick();
    chk("rr_level_pre", level, 2);
    rrst_n = 1'b0; #1;
    chk("rr_valid", m_valid, 0);
    chk("rr_level", level, 0);
    chk("rr_cnt", rd_cnt, 0);
    chk("rr_rinc", rinc, 0);
    chk("rr_data", m_data, 0);
    q.delete();
    update_fifo();
    #2 rrst_n = 1'b1;
    tick(); tick();
    chk("rr_valid_post", m_valid, 0);
    chk("rr_level_post", level, 0);
    chk("rr_cnt_post", rd_cnt, 0);
    chk("rr_rinc_post", rinc, 0);

    // Wrap: 4-bit counter over 17 words
    rempty_w = 1'b0; m_ready_w = 1'b1; #1;
    chk("wr_rinc", rinc_w, 1);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 16) chk("wr_cnt15", rd_cnt_w, 15);
      if (k == 17) chk("wr_cnt16", rd_cnt_w, 0);
      if (k == 18) chk("wr_cnt17", rd_cnt_w, 1);
    end
    chk("wr_data", m_data_w, 8'h5A);
    chk("wr_level", level_w, 1);
    chk("wr_valid", m_valid_w, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_fifo_rd_stream
